// File: rtl/warp_reg_bank.sv
// warp_reg_bank: multi-warp per-lane register file for the SM core.
//  - 32 architectural registers per lane; r1..r28 are stored, r0/r29/r30/r31 are synthesized on read.
//  - 1-cycle registered operand read, separate ALU and LSU write-back ports.
//  - Per-warp scoreboard of outstanding loads stalls reads of pending registers.
//  - Launch FSM zeroes r1..r28 of a warp (one register per cycle) and latches its block context.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write data forwarded to the read output).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_reg_bank #(
   parameter int  NUM_WARPS        = 4,
   parameter int  THREADS_PER_WARP = 16,
   parameter int  DATA_WIDTH       = `DATA_WIDTH,
   localparam int WARP_W           = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int VEC_W            = DATA_WIDTH * THREADS_PER_WARP
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        launch_valid,
   output logic                        launch_ready,
   input  logic [WARP_W-1:0]           launch_warp,
   input  logic [DATA_WIDTH-1:0]       launch_block_id,
   input  logic [DATA_WIDTH-1:0]       launch_block_size,
   input  logic                        rd_valid,
   output logic                        rd_ready,
   input  logic [WARP_W-1:0]           rd_warp,
   input  logic [4:0]                  rd_rs1,
   input  logic [4:0]                  rd_rs2,
   output logic                        rd_data_valid,
   output logic [VEC_W-1:0]            rs1_data,
   output logic [VEC_W-1:0]            rs2_data,
   input  logic                        reserve_valid,
   input  logic [WARP_W-1:0]           reserve_warp,
   input  logic [4:0]                  reserve_rd,
   input  logic                        alu_wr_valid,
   input  logic [WARP_W-1:0]           alu_wr_warp,
   input  logic [4:0]                  alu_wr_rd,
   input  logic [THREADS_PER_WARP-1:0] alu_wr_mask,
   input  logic [VEC_W-1:0]            alu_wr_data,
   input  logic                        lsu_wr_valid,
   input  logic [WARP_W-1:0]           lsu_wr_warp,
   input  logic [4:0]                  lsu_wr_rd,
   input  logic [THREADS_PER_WARP-1:0] lsu_wr_mask,
   input  logic [VEC_W-1:0]            lsu_wr_data,
   output logic                        waw_err
);

   localparam logic [4:0] LAST_GPR = 5'd28;

`ifdef REG_FILE_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_reg, state_next;
   logic [4:0]          cnt_reg, cnt_next;
   logic [WARP_W-1:0]   clr_warp_reg, clr_warp_next;

   // Indices 0 and 29..31 are never written; they exist only to keep indexing direct.
   logic [VEC_W-1:0]      gpr            [NUM_WARPS][32];
   logic [DATA_WIDTH-1:0] block_id_reg   [NUM_WARPS];
   logic [DATA_WIDTH-1:0] block_size_reg [NUM_WARPS];
   logic [31:0]           pend_reg       [NUM_WARPS];
   logic [31:0]           pend_next      [NUM_WARPS];

   logic clearing, launch_fire;
   logic alu_en, lsu_en, rsv_en, waw_hit;
   logic alu_hit1, alu_hit2, lsu_hit1, lsu_hit2;
   logic stall1, stall2, warp_busy, rd_fire;
   logic [VEC_W-1:0] rs1_next, rs2_next;

   function automatic logic is_gpr(input logic [4:0] r);
      return (r != 5'd0) && (r <= LAST_GPR);
   endfunction

   // Per-lane read value: special registers first, then optional ALU/LSU forwarding (LSU last, so it wins).
   function automatic logic [DATA_WIDTH-1:0] sel_lane(
      input logic [4:0]            rs,
      input logic [DATA_WIDTH-1:0] stored,
      input logic [DATA_WIDTH-1:0] lane_id,
      input logic [DATA_WIDTH-1:0] bid,
      input logic [DATA_WIDTH-1:0] bsz,
      input logic                  alu_fwd,
      input logic [DATA_WIDTH-1:0] alu_d,
      input logic                  lsu_fwd,
      input logic [DATA_WIDTH-1:0] lsu_d
   );
      logic [DATA_WIDTH-1:0] v;
      case (rs)
         5'd0:    v = '0;
         5'd29:   v = lane_id;
         5'd30:   v = bid;
         5'd31:   v = bsz;
         default: v = stored;
      endcase
      if (alu_fwd) v = alu_d;
      if (lsu_fwd) v = lsu_d;
      return v;
   endfunction

   assign clearing     = (state_reg == CLEAR);
   assign launch_ready = (state_reg == IDLE);
   assign launch_fire  = launch_valid && launch_ready;

   // Traffic aimed at special registers or at the warp being cleared is dropped.
   assign alu_en  = alu_wr_valid  && is_gpr(alu_wr_rd)  && !(clearing && (alu_wr_warp  == clr_warp_reg));
   assign lsu_en  = lsu_wr_valid  && is_gpr(lsu_wr_rd)  && !(clearing && (lsu_wr_warp  == clr_warp_reg));
   assign rsv_en  = reserve_valid && is_gpr(reserve_rd) && !(clearing && (reserve_warp == clr_warp_reg));
   assign waw_hit = alu_en && lsu_en && (alu_wr_warp == lsu_wr_warp) && (alu_wr_rd == lsu_wr_rd);

   assign alu_hit1 = alu_en && (alu_wr_warp == rd_warp) && (alu_wr_rd == rd_rs1);
   assign alu_hit2 = alu_en && (alu_wr_warp == rd_warp) && (alu_wr_rd == rd_rs2);
   assign lsu_hit1 = lsu_en && (lsu_wr_warp == rd_warp) && (lsu_wr_rd == rd_rs1);
   assign lsu_hit2 = lsu_en && (lsu_wr_warp == rd_warp) && (lsu_wr_rd == rd_rs2);

   // With forwarding, a pending bit being cleared by this cycle's LSU write no longer blocks the read.
   assign stall1    = pend_reg[rd_warp][rd_rs1] && !(BYPASS && lsu_hit1);
   assign stall2    = pend_reg[rd_warp][rd_rs2] && !(BYPASS && lsu_hit2);
   assign warp_busy = clearing && (rd_warp == clr_warp_reg);
   assign rd_ready  = rd_valid && !stall1 && !stall2 && !warp_busy;
   assign rd_fire   = rd_ready;

   for (genvar gi = 0; gi < THREADS_PER_WARP; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_id;
      assign lane_id = DATA_WIDTH'(int'(rd_warp) * THREADS_PER_WARP + gi);

      assign rs1_next[gi*DATA_WIDTH +: DATA_WIDTH] = sel_lane(
         rd_rs1, gpr[rd_warp][rd_rs1][gi*DATA_WIDTH +: DATA_WIDTH], lane_id,
         block_id_reg[rd_warp], block_size_reg[rd_warp],
         BYPASS && alu_hit1 && alu_wr_mask[gi], alu_wr_data[gi*DATA_WIDTH +: DATA_WIDTH],
         BYPASS && lsu_hit1 && lsu_wr_mask[gi], lsu_wr_data[gi*DATA_WIDTH +: DATA_WIDTH]);

      assign rs2_next[gi*DATA_WIDTH +: DATA_WIDTH] = sel_lane(
         rd_rs2, gpr[rd_warp][rd_rs2][gi*DATA_WIDTH +: DATA_WIDTH], lane_id,
         block_id_reg[rd_warp], block_size_reg[rd_warp],
         BYPASS && alu_hit2 && alu_wr_mask[gi], alu_wr_data[gi*DATA_WIDTH +: DATA_WIDTH],
         BYPASS && lsu_hit2 && lsu_wr_mask[gi], lsu_wr_data[gi*DATA_WIDTH +: DATA_WIDTH]);
   end

   // Launch FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= 5'd0;
         clr_warp_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         clr_warp_reg <= clr_warp_next;
      end
   end

   // Launch FSM next state: sweep cnt over r1..r28 of the launching warp, one register per cycle
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      clr_warp_next = clr_warp_reg;
      case (state_reg)
         IDLE: begin
            if (launch_fire) begin
               state_next    = CLEAR;
               cnt_next      = 5'd1;
               clr_warp_next = launch_warp;
            end
         end
         CLEAR: begin
            cnt_next = cnt_reg + 5'd1;
            if (cnt_reg == LAST_GPR) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Block context latched on launch accept; left unreset because it is meaningless before a launch
   always_ff @(posedge clk) begin
      if (launch_fire) begin
         block_id_reg[launch_warp]   <= launch_block_id;
         block_size_reg[launch_warp] <= launch_block_size;
      end
   end

   // GPR storage: ALU then LSU lane writes (LSU wins on a collision), plus the launch clear sweep
   always_ff @(posedge clk) begin
      for (int l = 0; l < THREADS_PER_WARP; l++) begin
         if (alu_en && alu_wr_mask[l])
            gpr[alu_wr_warp][alu_wr_rd][l*DATA_WIDTH +: DATA_WIDTH] <= alu_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
         if (lsu_en && lsu_wr_mask[l])
            gpr[lsu_wr_warp][lsu_wr_rd][l*DATA_WIDTH +: DATA_WIDTH] <= lsu_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
      if (clearing) gpr[clr_warp_reg][cnt_reg] <= '0;
   end

   // Scoreboard next state: LSU clears, reserve sets (reserve wins), launch wipes the whole warp
   always_comb begin
      pend_next = pend_reg;
      if (lsu_en)      pend_next[lsu_wr_warp][lsu_wr_rd]   = 1'b0;
      if (rsv_en)      pend_next[reserve_warp][reserve_rd] = 1'b1;
      if (launch_fire) pend_next[launch_warp]              = '0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int w = 0; w < NUM_WARPS; w++) pend_reg[w] <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   // Registered operand output: data held until the next accepted read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_valid <= 1'b0;
         rs1_data      <= '0;
         rs2_data      <= '0;
      end else begin
         rd_data_valid <= rd_fire;
         if (rd_fire) begin
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
         end
      end
   end

   // Sticky write-after-write collision flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     waw_err <= 1'b0;
      else if (waw_hit) waw_err <= 1'b1;
   end

endmodule

// File: tb/tb_warp_reg_bank.sv
// Testbench for warp_reg_bank: directed scenarios plus randomized traffic checked against
// an array-based reference model of the register bank (values, scoreboard, launch sweep).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_warp_reg_bank;

   localparam int NW  = 4;
   localparam int TPW = 16;
   localparam int DW  = `DATA_WIDTH;
   localparam int WW  = 2;
   localparam int FW  = DW * TPW;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic launch_valid, launch_ready;
   logic [WW-1:0] launch_warp;
   logic [DW-1:0] launch_block_id, launch_block_size;
   logic rd_valid, rd_ready;
   logic [WW-1:0] rd_warp;
   logic [4:0] rd_rs1, rd_rs2;
   logic rd_data_valid;
   logic [FW-1:0] rs1_data, rs2_data;
   logic reserve_valid;
   logic [WW-1:0] reserve_warp;
   logic [4:0] reserve_rd;
   logic alu_wr_valid;
   logic [WW-1:0] alu_wr_warp;
   logic [4:0] alu_wr_rd;
   logic [TPW-1:0] alu_wr_mask;
   logic [FW-1:0] alu_wr_data;
   logic lsu_wr_valid;
   logic [WW-1:0] lsu_wr_warp;
   logic [4:0] lsu_wr_rd;
   logic [TPW-1:0] lsu_wr_mask;
   logic [FW-1:0] lsu_wr_data;
   logic waw_err;

   always #5 clk = ~clk;

   warp_reg_bank #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_warp(launch_warp),
      .launch_block_id(launch_block_id), .launch_block_size(launch_block_size),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_warp(rd_warp), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
      .rd_data_valid(rd_data_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .reserve_valid(reserve_valid), .reserve_warp(reserve_warp), .reserve_rd(reserve_rd),
      .alu_wr_valid(alu_wr_valid), .alu_wr_warp(alu_wr_warp), .alu_wr_rd(alu_wr_rd),
      .alu_wr_mask(alu_wr_mask), .alu_wr_data(alu_wr_data),
      .lsu_wr_valid(lsu_wr_valid), .lsu_wr_warp(lsu_wr_warp), .lsu_wr_rd(lsu_wr_rd),
      .lsu_wr_mask(lsu_wr_mask), .lsu_wr_data(lsu_wr_data),
      .waw_err(waw_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] m_gpr [NW][32][TPW];
   bit            m_pend [NW][32];
   logic [DW-1:0] m_bid [NW];
   logic [DW-1:0] m_bsz [NW];
   int            m_busy;      // remaining clear cycles, 0 when idle
   int            m_clr_idx;   // next register the launch sweep zeroes
   int            m_clr_warp;
   bit            m_waw;
   bit            last_ready;

   task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_gpr(input int r);
      return (r >= 1) && (r <= 28);
   endfunction

   function automatic logic [FW-1:0] splat(input logic [DW-1:0] v);
      logic [FW-1:0] r;
      for (int l = 0; l < TPW; l++) r[l*DW +: DW] = v;
      return r;
   endfunction

   // Value a read of (w, rs) returns this cycle: pre-write contents, optionally overlaid with same-cycle writes
   function automatic logic [FW-1:0] model_read(input int w, input int rs, input bit alu_ok, input bit lsu_ok);
      logic [FW-1:0] v;
      logic [DW-1:0] x;
      for (int l = 0; l < TPW; l++) begin
         if (rs == 0)       x = '0;
         else if (rs == 29) x = DW'(w * TPW + l);
         else if (rs == 30) x = m_bid[w];
         else if (rs == 31) x = m_bsz[w];
         else               x = m_gpr[w][rs][l];
         if (BYP) begin
            if (alu_ok && int'(alu_wr_warp) == w && int'(alu_wr_rd) == rs && alu_wr_mask[l])
               x = alu_wr_data[l*DW +: DW];
            if (lsu_ok && int'(lsu_wr_warp) == w && int'(lsu_wr_rd) == rs && lsu_wr_mask[l])
               x = lsu_wr_data[l*DW +: DW];
         end
         v[l*DW +: DW] = x;
      end
      return v;
   endfunction

   function automatic bit blocked(input int w, input int rs, input bit lsu_ok);
      bit freed;
      freed = BYP && lsu_ok && int'(lsu_wr_warp) == w && int'(lsu_wr_rd) == rs;
      return m_pend[w][rs] && !freed;
   endfunction

   task automatic idle_inputs();
      launch_valid = 1'b0; launch_warp = '0; launch_block_id = '0; launch_block_size = '0;
      rd_valid = 1'b0; rd_warp = '0; rd_rs1 = '0; rd_rs2 = '0;
      reserve_valid = 1'b0; reserve_warp = '0; reserve_rd = '0;
      alu_wr_valid = 1'b0; alu_wr_warp = '0; alu_wr_rd = '0; alu_wr_mask = '0; alu_wr_data = '0;
      lsu_wr_valid = 1'b0; lsu_wr_warp = '0; lsu_wr_rd = '0; lsu_wr_mask = '0; lsu_wr_data = '0;
   endtask

   task automatic model_reset();
      for (int w = 0; w < NW; w++)
         for (int r = 0; r < 32; r++) m_pend[w][r] = 1'b0;
      m_busy = 0; m_clr_idx = 0; m_clr_warp = 0; m_waw = 1'b0;
   endtask

   // One clock cycle with inputs already driven at the preceding negedge; checks and advances the model
   task automatic do_cycle();
      bit clearing, alu_ok, lsu_ok, rsv_ok, exp_ready, launch_ok;
      logic [FW-1:0] e1, e2;
      int rw, r1, r2, aw, ar, lw, lr;
      #1;
      clearing = (m_busy > 0);
      aw = int'(alu_wr_warp); ar = int'(alu_wr_rd);
      lw = int'(lsu_wr_warp); lr = int'(lsu_wr_rd);
      alu_ok = alu_wr_valid && is_gpr(ar) && !(clearing && aw == m_clr_warp);
      lsu_ok = lsu_wr_valid && is_gpr(lr) && !(clearing && lw == m_clr_warp);
      rsv_ok = reserve_valid && is_gpr(int'(reserve_rd)) && !(clearing && int'(reserve_warp) == m_clr_warp);
      rw = int'(rd_warp); r1 = int'(rd_rs1); r2 = int'(rd_rs2);
      exp_ready = rd_valid && !blocked(rw, r1, lsu_ok) && !blocked(rw, r2, lsu_ok)
                  && !(clearing && rw == m_clr_warp);
      launch_ok = launch_valid && !clearing;
      last_ready = rd_ready;
      check_eq("launch_ready", FW'(launch_ready), FW'(!clearing));
      check_eq("rd_ready", FW'(rd_ready), FW'(exp_ready));
      e1 = '0; e2 = '0;
      if (exp_ready) begin
         e1 = model_read(rw, r1, alu_ok, lsu_ok);
         e2 = model_read(rw, r2, alu_ok, lsu_ok);
      end
      for (int l = 0; l < TPW; l++) begin
         if (alu_ok && alu_wr_mask[l]) m_gpr[aw][ar][l] = alu_wr_data[l*DW +: DW];
         if (lsu_ok && lsu_wr_mask[l]) m_gpr[lw][lr][l] = lsu_wr_data[l*DW +: DW];
      end
      if (clearing) begin
         for (int l = 0; l < TPW; l++) m_gpr[m_clr_warp][m_clr_idx][l] = '0;
         m_clr_idx++;
         m_busy--;
      end
      if (lsu_ok) m_pend[lw][lr] = 1'b0;
      if (rsv_ok) m_pend[int'(reserve_warp)][int'(reserve_rd)] = 1'b1;
      if (alu_ok && lsu_ok && aw == lw && ar == lr) m_waw = 1'b1;
      if (launch_ok) begin
         m_bid[int'(launch_warp)] = launch_block_id;
         m_bsz[int'(launch_warp)] = launch_block_size;
         for (int r = 0; r < 32; r++) m_pend[int'(launch_warp)][r] = 1'b0;
         m_busy = 28; m_clr_idx = 1; m_clr_warp = int'(launch_warp);
      end
      @(posedge clk);
      #1;
      check_eq("rd_data_valid", FW'(rd_data_valid), FW'(exp_ready));
      if (exp_ready) begin
         check_eq("rs1_data", rs1_data, e1);
         check_eq("rs2_data", rs2_data, e2);
      end
      check_eq("waw_err", FW'(waw_err), FW'(m_waw));
   endtask

   task automatic read_cycle(input int w, input int a, input int b);
      @(negedge clk);
      idle_inputs();
      rd_valid = 1'b1; rd_warp = WW'(w); rd_rs1 = 5'(a); rd_rs2 = 5'(b);
      do_cycle();
   endtask

   task automatic drive_random();
      launch_valid = ($urandom_range(0, 59) == 0);
      launch_warp = WW'($urandom_range(0, NW-1));
      launch_block_id = DW'($urandom); launch_block_size = DW'($urandom);
      rd_valid = ($urandom_range(0, 9) < 6);
      rd_warp = WW'($urandom_range(0, NW-1));
      rd_rs1 = 5'($urandom); rd_rs2 = 5'($urandom);
      reserve_valid = ($urandom_range(0, 5) == 0);
      reserve_warp = WW'($urandom_range(0, NW-1)); reserve_rd = 5'($urandom);
      alu_wr_valid = ($urandom_range(0, 2) == 0);
      alu_wr_warp = WW'($urandom_range(0, NW-1)); alu_wr_rd = 5'($urandom);
      alu_wr_mask = TPW'($urandom);
      lsu_wr_valid = ($urandom_range(0, 2) == 0);
      lsu_wr_warp = WW'($urandom_range(0, NW-1)); lsu_wr_rd = 5'($urandom);
      lsu_wr_mask = TPW'($urandom);
      for (int l = 0; l < TPW; l++) begin
         alu_wr_data[l*DW +: DW] = DW'($urandom);
         lsu_wr_data[l*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin lsu_wr_warp = rd_warp; lsu_wr_rd = rd_rs1; end
      if ($urandom_range(0, 7) == 0) begin alu_wr_warp = lsu_wr_warp; alu_wr_rd = lsu_wr_rd; end
   endtask

   initial begin
      logic [FW-1:0] exp_v;
      idle_inputs();
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_launch_ready", FW'(launch_ready), FW'(1));
      check_eq("rst_rd_data_valid", FW'(rd_data_valid), FW'(0));
      check_eq("rst_rs1_data", rs1_data, '0);
      check_eq("rst_rs2_data", rs2_data, '0);
      check_eq("rst_waw_err", FW'(waw_err), FW'(0));
      @(negedge clk);
      reset_n = 1'b1;

      // Launch every warp; w1 carries bid=7, bsz=64
      for (int w = 0; w < NW; w++) begin
         @(negedge clk);
         idle_inputs();
         launch_valid = 1'b1; launch_warp = WW'(w);
         launch_block_id   = (w == 1) ? DW'(7)  : DW'(w + 3);
         launch_block_size = (w == 1) ? DW'(64) : DW'(32 * (w + 1));
         do_cycle();
         repeat (28) begin
            @(negedge clk);
            idle_inputs();
            do_cycle();
         end
      end

      // Special registers on w1 and a freshly zeroed GPR
      read_cycle(1, 29, 30);
      for (int l = 0; l < TPW; l++) exp_v[l*DW +: DW] = DW'(16 + l);
      check_eq("w1_r29_lane_id", rs1_data, exp_v);
      check_eq("w1_r30_block_id", rs2_data, splat(DW'(7)));
      read_cycle(1, 5, 31);
      check_eq("w1_r5_zeroed", rs1_data, '0);
      check_eq("w1_r31_block_size", rs2_data, splat(DW'(64)));

      // Masked ALU write, lanes 0-7 only
      @(negedge clk);
      idle_inputs();
      alu_wr_valid = 1'b1; alu_wr_warp = 2'd0; alu_wr_rd = 5'd5; alu_wr_mask = 16'h00FF;
      alu_wr_data = splat(DW'(32'hA5));
      do_cycle();
      read_cycle(0, 5, 0);
      for (int l = 0; l < TPW; l++) exp_v[l*DW +: DW] = (l < 8) ? DW'(32'hA5) : DW'(0);
      check_eq("w0_r5_masked", rs1_data, exp_v);

      // Scoreboard stall until the load returns
      @(negedge clk);
      idle_inputs();
      reserve_valid = 1'b1; reserve_warp = 2'd2; reserve_rd = 5'd3;
      do_cycle();
      repeat (3) begin
         read_cycle(2, 3, 0);
         check_eq("pend_stall", FW'(last_ready), FW'(0));
      end
      @(negedge clk);
      idle_inputs();
      rd_valid = 1'b1; rd_warp = 2'd2; rd_rs1 = 5'd3;
      lsu_wr_valid = 1'b1; lsu_wr_warp = 2'd2; lsu_wr_rd = 5'd3; lsu_wr_mask = '1;
      lsu_wr_data = splat(DW'(32'h55));
      do_cycle();
      check_eq("load_return_read", FW'(last_ready), FW'(BYP));
      if (BYP) check_eq("load_forward_data", rs1_data, splat(DW'(32'h55)));
      read_cycle(2, 3, 0);
      check_eq("after_load_ready", FW'(last_ready), FW'(1));
      check_eq("after_load_data", rs1_data, splat(DW'(32'h55)));

      // ALU/LSU collision on w0 r4; ignored writes to r0/r31
      @(negedge clk);
      idle_inputs();
      alu_wr_valid = 1'b1; alu_wr_warp = 2'd0; alu_wr_rd = 5'd4; alu_wr_mask = '1;
      alu_wr_data = splat(DW'(32'h1111));
      lsu_wr_valid = 1'b1; lsu_wr_warp = 2'd0; lsu_wr_rd = 5'd4; lsu_wr_mask = '1;
      lsu_wr_data = splat(DW'(32'h2222));
      do_cycle();
      check_eq("waw_set", FW'(waw_err), FW'(1));
      read_cycle(0, 4, 0);
      check_eq("waw_lsu_wins", rs1_data, splat(DW'(32'h2222)));
      @(negedge clk);
      idle_inputs();
      alu_wr_valid = 1'b1; alu_wr_warp = 2'd0; alu_wr_rd = 5'd0; alu_wr_mask = '1;
      alu_wr_data = '1;
      lsu_wr_valid = 1'b1; lsu_wr_warp = 2'd0; lsu_wr_rd = 5'd31; lsu_wr_mask = '1;
      lsu_wr_data = '1;
      do_cycle();
      read_cycle(0, 0, 31);
      check_eq("r0_ignored", rs1_data, '0);
      check_eq("r31_ignored", rs2_data, splat(DW'(32)));

      // Randomized traffic against the model
      repeat (1500) begin
         @(negedge clk);
         drive_random();
         do_cycle();
      end
      repeat (30) begin
         @(negedge clk);
         idle_inputs();
         do_cycle();
      end

      // Reset in the middle of a clear sweep
      @(negedge clk);
      idle_inputs();
      reserve_valid = 1'b1; reserve_warp = 2'd0; reserve_rd = 5'd7;
      do_cycle();
      read_cycle(0, 7, 0);
      check_eq("pre_reset_stall", FW'(last_ready), FW'(0));
      @(negedge clk);
      idle_inputs();
      launch_valid = 1'b1; launch_warp = 2'd3; launch_block_id = DW'(1); launch_block_size = DW'(2);
      do_cycle();
      repeat (9) begin
         @(negedge clk);
         idle_inputs();
         do_cycle();
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check_eq("mid_clear_busy", FW'(launch_ready), FW'(0));
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_eq("async_rst_launch_ready", FW'(launch_ready), FW'(1));
      check_eq("async_rst_rd_data_valid", FW'(rd_data_valid), FW'(0));
      check_eq("async_rst_waw_err", FW'(waw_err), FW'(0));
      check_eq("async_rst_rs1_data", rs1_data, '0);
      @(posedge clk);
      #1;
      check_eq("rst_edge_rd_data_valid", FW'(rd_data_valid), FW'(0));
      check_eq("rst_edge_launch_ready", FW'(launch_ready), FW'(1));
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      idle_inputs();
      rd_valid = 1'b1; rd_warp = 2'd0; rd_rs1 = 5'd7; rd_rs2 = 5'd0;
      #1;
      check_eq("post_rst_pend_clear", FW'(rd_ready), FW'(1));
      @(posedge clk);
      #1;
      check_eq("post_rst_rd_data_valid", FW'(rd_data_valid), FW'(1));
      @(negedge clk);
      idle_inputs();
      rd_valid = 1'b1; rd_warp = 2'd3; rd_rs1 = 5'd1; rd_rs2 = 5'd2;
      #1;
      check_eq("post_rst_not_clearing", FW'(rd_ready), FW'(1));
      @(negedge clk);
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
      $finish;
   end

endmodule
